rr_arb4x32: RTL and testbench
=============================

# rr_arb4x32

Four-source round-robin arbiter with a one-entry registered output stage. It sits directly upstream of the consumer of a 4:1 32-bit word select. It generates the 2-bit select `S` that drives a `MUX32X4` instance over `X3..X0`, and captures the selected word into an output register with a valid/ready handshake. It gives fair, starvation-free sharing of one 32-bit path among four producers.

## Interface
- `WIDTH`, 32, data width of each source and of the output.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `X3, X2, X1, X0`  in  WIDTH  source data words.
- `req_valid`  in  4  bit i: source i has a word on `Xi`.
- `req_ready`  out  4  bit i: source i's word is taken this cycle. One-hot or zero.
- `S`  out  2  current grant index; drives the `MUX32X4` select.
- `out_valid`  out  1  output register holds a word.
- `out_ready`  in  1  consumer accepts the word this cycle.
- `out_data`  out  WIDTH  registered selected word.
- `out_src`  out  2  index of the source that produced `out_data`.

## Operation
- **Priority pointer `ptr`** (2 bits) names the highest-priority source. Search order is `ptr`, `ptr+1`, `ptr+2`, `ptr+3`, mod 4.
- **Grant `g`** (combinational) is the first index in search order with `req_valid` set. `any = |req_valid`.
- **Select**
  - `S = g` when `any` is high.
  - Otherwise `S` holds the last registered grant.
  - `S` never changes while no request is pending.
- **Load enable:** `load = !out_valid || out_ready`.
- **Accept:** `req_ready[i] = load && any && (g == i)`. A transfer from source i occurs when `req_valid[i] && req_ready[i]`.
- **On accept:**
  - `out_data <=` the mux output for `S`.
  - `out_src <= g`.
  - `out_valid <= 1`.
  - `ptr <= g + 1` (wraps 3→0).
  - Last-grant register `<= g`.
- **Drain without refill:** when `out_valid && out_ready && !any`, set `out_valid <= 0`. `out_data` and `out_src` hold their old values.
- **Stall:** when `out_valid && !out_ready`, `out_data`, `out_src` and `ptr` are frozen and `req_ready = 0`.
- **Fairness:** a source held valid is granted within at most 4 accepted transfers.
- **Pointer movement:** `ptr` only moves on an accept, never on an idle or stalled cycle.
- **Width:** all index arithmetic is 2-bit modulo 4. No data arithmetic.

## Timing
- **Reset:** when `rst_n` is low at a rising edge, the following values are loaded. Reset has priority over all other updates, and any in-flight word is discarded.
  - `out_valid = 0`
  - `out_data = 0`
  - `out_src = 0`
  - `ptr = 0`
  - last grant `= 0`, so `S = 0`
  - `req_ready = 0` in the reset cycle
- **Latency:** 1 cycle. A word accepted at edge n appears on `out_data` with `out_valid = 1` after edge n.
- **Throughput:** one word per cycle while `out_ready` is held high and `any` is high.
- **Simultaneous drain and refill:** `out_valid && out_ready && any` replaces the word in the same edge, and `out_valid` stays 1.
- **Handshake rules:**
  - `req_ready` and `S` are combinational from `req_valid`, `ptr`, `out_valid` and `out_ready`.
  - `out_valid`, `out_data` and `out_src` are registered only.
  - There is no combinational path from `X*` to any output.
- **Source drop:** a source dropping `req_valid` in a cycle it was not accepted loses nothing. Arbitration is recomputed every cycle.

## Test plan
- **Reset mid-stream:** run continuous transfers, then assert `rst_n = 0` for one edge → `out_valid = 0`, `out_data = 0`, `out_src = 0`, `S = 0`. First grant after release goes to the lowest valid index ≥ 0.
- **Full contention:** all four valid, `out_ready = 1`, `X0..X3 = 0xA0..0xA3` → `out_src` sequence 0,1,2,3,0,… and `out_data` 0xA0,0xA1,0xA2,0xA3,0xA0 on consecutive cycles. Exactly one `req_ready` bit is high per cycle.
- **Backpressure:** all valid, accept source 0, then `out_ready = 0` for 3 cycles → `out_data = 0xA0` held and `req_ready = 0000`. With `out_ready = 1` on the 4th cycle, the next word 0xA1 is loaded in that same cycle.
- **Sparse/wrap:** only sources 3 and 1 valid, `ptr = 0` after reset → grants 1,3,1,3. Pointer wraps 3→0 correctly: after a source-3 grant, source 1 wins over a newly valid source 2.
- **Idle hold:** after granting 2, drop all `req_valid` with `out_ready = 1` → `out_valid` falls after one edge, `S` stays 2, and `ptr` stays 3. Re-raise sources 0 and 3 together → 3 is granted first.
- **Single source:** only source 2 valid with `X2 = 0xDEADBEEF` and `out_ready` toggling 1/0 → each word is transferred exactly once, with no duplicates or drops. Count of accepts equals count of `out_valid && out_ready` cycles.

Source files
------------

// File: rtl/rr_arb4x32_if.sv
// Bundle of the four source words, the request handshake and the registered
// output handshake shared between the round-robin arbiter and its neighbours.
interface rr_arb4x32_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] X3;
   logic [WIDTH-1:0] X2;
   logic [WIDTH-1:0] X1;
   logic [WIDTH-1:0] X0;
   logic [3:0]       req_valid;
   logic [3:0]       req_ready;
   logic [1:0]       S;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [1:0]       out_src;

   modport slave (
      input  X3, X2, X1, X0, req_valid, out_ready,
      output req_ready, S, out_valid, out_data, out_src
   );

   modport master (
      output X3, X2, X1, X0, req_valid, out_ready,
      input  req_ready, S, out_valid, out_data, out_src
   );
endinterface

// File: rtl/rr_arb4x32.sv
// Four-source round-robin arbiter feeding a one-entry registered output stage;
// the rotating pointer makes the source after the last winner top priority.
module rr_arb4x32 #(
   parameter int WIDTH = 32
) (
   input logic            clk,
   input logic            rst_n,
   rr_arb4x32_if.slave    bus
);
   logic [1:0]       ptr_q, ptr_d;
   logic [1:0]       lastGrant_q, lastGrant_d;
   logic             outValid_q, outValid_d;
   logic [WIDTH-1:0] outData_q, outData_d;
   logic [1:0]       outSrc_q, outSrc_d;

   logic [1:0]       grant;
   logic [1:0]       idx;
   logic             found;
   logic             anyReq;
   logic             load;
   logic             accept;
   logic [1:0]       sel;
   logic [WIDTH-1:0] muxOut;

   assign anyReq = |bus.req_valid;

   // First requester at or after the priority pointer, wrapping modulo 4.
   always_comb begin
      grant = 2'd0;
      idx   = 2'd0;
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
         idx = ptr_q + 2'(k);
         if (!found && bus.req_valid[idx]) begin
            grant = idx;
            found = 1'b1;
         end
      end
   end

   assign load   = !outValid_q || bus.out_ready;
   assign accept = load && anyReq;
   assign sel    = anyReq ? grant : lastGrant_q;

   always_comb begin
      muxOut = bus.X0;
      case (sel)
         2'd0:    muxOut = bus.X0;
         2'd1:    muxOut = bus.X1;
         2'd2:    muxOut = bus.X2;
         default: muxOut = bus.X3;
      endcase
   end

   // Ready is suppressed while reset is asserted so nothing is taken in that cycle.
   always_comb begin
      bus.req_ready = 4'b0000;
      if (rst_n && accept) begin
         bus.req_ready[grant] = 1'b1;
      end
   end

   always_comb begin
      ptr_d       = ptr_q;
      lastGrant_d = lastGrant_q;
      outValid_d  = outValid_q;
      outData_d   = outData_q;
      outSrc_d    = outSrc_q;
      if (accept) begin
         ptr_d       = grant + 2'd1;
         lastGrant_d = grant;
         outValid_d  = 1'b1;
         outData_d   = muxOut;
         outSrc_d    = grant;
      end else if (outValid_q && bus.out_ready) begin
         outValid_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q       <= 2'd0;
         lastGrant_q <= 2'd0;
         outValid_q  <= 1'b0;
         outData_q   <= '0;
         outSrc_q    <= 2'd0;
      end else begin
         ptr_q       <= ptr_d;
         lastGrant_q <= lastGrant_d;
         outValid_q  <= outValid_d;
         outData_q   <= outData_d;
         outSrc_q    <= outSrc_d;
      end
   end

   assign bus.S         = sel;
   assign bus.out_valid = outValid_q;
   assign bus.out_data  = outData_q;
   assign bus.out_src   = outSrc_q;
endmodule

// File: tb/tb_rr_arb4x32.sv
// Bench for rr_arb4x32: directed scenarios then random traffic, each cycle
// compared against a behavioural round-robin model.
module tb_rr_arb4x32;
   logic clk;
   logic rst_n;

   rr_arb4x32_if #(.WIDTH(32)) bus ();

   rr_arb4x32 #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   logic [31:0] xv [4];

   // Behavioural model: priority pointer as a plain integer, output stage as values.
   int          mPtr;
   logic [1:0]  mLast;
   logic        mValid;
   logic [31:0] mData;
   logic [1:0]  mSrc;
   int          mAccepts;
   int          conCnt;

   function automatic int modelGrant(input logic [3:0] v, input int p);
      for (int k = 0; k < 4; k++) begin
         if (v[(p + k) % 4]) return (p + k) % 4;
      end
      return -1;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic modelReset();
      mPtr   = 0;
      mLast  = 2'd0;
      mValid = 1'b0;
      mData  = 32'd0;
      mSrc   = 2'd0;
   endtask

   // One clock cycle: drive, check combinational outputs, clock, check registers.
   task automatic applyStimulus(input logic rstn, input logic [3:0] v, input logic rdy);
      int         g;
      logic       load;
      logic [3:0] expReady;
      logic [1:0] expS;
      rst_n         = rstn;
      bus.req_valid = v;
      bus.out_ready = rdy;
      bus.X0        = xv[0];
      bus.X1        = xv[1];
      bus.X2        = xv[2];
      bus.X3        = xv[3];
      #1;
      g        = modelGrant(v, mPtr);
      load     = !mValid || rdy;
      expReady = 4'b0000;
      if (rstn && load && g >= 0) expReady[g] = 1'b1;
      expS = (g >= 0) ? 2'(g) : mLast;
      checkOutput("req_ready", 32'(bus.req_ready), 32'(expReady));
      checkOutput("S", 32'(bus.S), 32'(expS));
      if (bus.out_valid && rdy) conCnt++;
      @(posedge clk);
      if (!rstn) begin
         modelReset();
      end else if (load && g >= 0) begin
         mData  = xv[g];
         mSrc   = 2'(g);
         mValid = 1'b1;
         mPtr   = (g + 1) % 4;
         mLast  = 2'(g);
         mAccepts++;
      end else if (mValid && rdy) begin
         mValid = 1'b0;
      end
      #1;
      checkOutput("out_valid", 32'(bus.out_valid), 32'(mValid));
      checkOutput("out_data", bus.out_data, mData);
      checkOutput("out_src", 32'(bus.out_src), 32'(mSrc));
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 4; i++) xv[i] = 32'hA0 + 32'(i);
      rst_n         = 1'b0;
      bus.req_valid = 4'b0000;
      bus.out_ready = 1'b0;
      bus.X0        = xv[0];
      bus.X1        = xv[1];
      bus.X2        = xv[2];
      bus.X3        = xv[3];
      mAccepts      = 0;
      conCnt        = 0;
      modelReset();
      repeat (2) @(posedge clk);
      @(negedge clk);

      $display("[TB] reset state");
      applyStimulus(1'b0, 4'b0000, 1'b0);
      applyStimulus(1'b0, 4'b1111, 1'b1);

      $display("[TB] full contention");
      for (int i = 0; i < 9; i++) applyStimulus(1'b1, 4'b1111, 1'b1);

      $display("[TB] reset mid-stream");
      applyStimulus(1'b0, 4'b1111, 1'b1);
      applyStimulus(1'b1, 4'b1111, 1'b1);

      $display("[TB] backpressure");
      applyStimulus(1'b0, 4'b0000, 1'b0);
      applyStimulus(1'b1, 4'b1111, 1'b1);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'b1111, 1'b0);
      applyStimulus(1'b1, 4'b1111, 1'b1);

      $display("[TB] sparse and wrap");
      applyStimulus(1'b0, 4'b0000, 1'b0);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 4'b1010, 1'b1);
      applyStimulus(1'b1, 4'b1110, 1'b1);
      applyStimulus(1'b1, 4'b1110, 1'b1);

      $display("[TB] idle hold");
      applyStimulus(1'b0, 4'b0000, 1'b0);
      applyStimulus(1'b1, 4'b0100, 1'b1);
      applyStimulus(1'b1, 4'b0000, 1'b1);
      applyStimulus(1'b1, 4'b0000, 1'b1);
      applyStimulus(1'b1, 4'b1001, 1'b1);
      applyStimulus(1'b1, 4'b1001, 1'b1);

      $display("[TB] single source");
      applyStimulus(1'b0, 4'b0000, 1'b0);
      xv[2]    = 32'hDEADBEEF;
      mAccepts = 0;
      conCnt   = 0;
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 4'b0100, 1'(i % 2 == 0));
      applyStimulus(1'b1, 4'b0000, 1'b1);
      applyStimulus(1'b1, 4'b0000, 1'b1);
      checkOutput("accept_vs_consume", 32'(conCnt), 32'(mAccepts));

      $display("[TB] random traffic");
      for (int i = 0; i < 300; i++) begin
         for (int j = 0; j < 4; j++) xv[j] = $urandom;
         applyStimulus(1'($urandom_range(0, 39) != 0), 4'($urandom_range(0, 15)),
                       1'($urandom_range(0, 3) != 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
